// File: rtl/copyread_requester.sv
// Per-lane copy-read requester: FIFOs byte-granular copy commands and issues 1-2 line-aligned requests.
// Optional COPYREAD_REQ_STATS_EN adds stall_cnt/req_cnt saturating counters.
module copyread_requester #(
  parameter int DEPTH = 4,
  parameter int AW    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW+2:0]   cmd_addr,
  input  logic [3:0]      cmd_len,
  input  logic [63:0]     cmd_data,
  output logic [AW+71:0]  req_out,
  output logic            req_valid,
  input  logic            rd_in,
  output logic            idle
`ifdef COPYREAD_REQ_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     req_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = AW + 3 + 4 + 64;

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND} state_t;

  typedef struct packed {
    logic [AW-1:0] line;
    logic [7:0]    mask1;
    logic [7:0]    mask2;
    logic [63:0]   data;
  } beat_t;

  // Clamp length, rotate payload into its byte lanes, and split the mask across two lines.
  function automatic beat_t decode(input logic [EW-1:0] e);
    logic [AW+2:0] a;
    logic [3:0]    l;
    logic [63:0]   d;
    logic [3:0]    n;
    logic [6:0]    sh;
    logic [15:0]   m;
    beat_t         b;
    {a, l, d} = e;
    n  = (l > 4'd8) ? 4'd8 : l;
    sh = {1'b0, a[2:0], 3'b000};
    m  = ((16'd1 << n) - 16'd1) << a[2:0];
    b.line  = a[AW+2:3];
    b.mask1 = m[7:0];
    b.mask2 = m[15:8];
    b.data  = (d << sh) | (d >> (7'd64 - sh));
    return b;
  endfunction

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [PW:0]   count;
  state_t        state, state_nx;

  logic [AW-1:0] req_line;
  logic [7:0]    req_mask, mask2_q;
  logic [63:0]   req_data;

  logic          push, pop, grant, load, load_second;
  logic [EW-1:0] in_entry, load_entry;
  beat_t         load_beat;

  assign cmd_ready = (count < (PW+1)'(DEPTH));
  assign push      = cmd_valid & cmd_ready & (cmd_len != 4'd0);
  assign grant     = req_valid & rd_in;
  assign in_entry  = {cmd_addr, cmd_len, cmd_data};
  assign rd_ptr_nx = rd_ptr + PW'(1);
  assign load_beat = decode(load_entry);
  assign req_out   = {req_line, req_mask, req_data};
  assign idle      = (count == '0) && (state == S_IDLE);

  // The head stays in the FIFO until its last half is granted; an empty FIFO
  // forwards the incoming command straight into the output register.
  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    load        = 1'b0;
    load_second = 1'b0;
    load_entry  = in_entry;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          load       = 1'b1;
          load_entry = mem[rd_ptr];
          state_nx   = S_FIRST;
        end else if (push) begin
          load     = 1'b1;
          state_nx = S_FIRST;
        end
      end
      S_FIRST, S_SECOND: begin
        if (grant) begin
          if (state == S_FIRST && mask2_q != '0) begin
            load_second = 1'b1;
            state_nx    = S_SECOND;
          end else begin
            pop = 1'b1;
            if (count > (PW+1)'(1)) begin
              load       = 1'b1;
              load_entry = mem[rd_ptr_nx];
              state_nx   = S_FIRST;
            end else if (push) begin
              load     = 1'b1;
              state_nx = S_FIRST;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= S_IDLE;
      req_valid <= 1'b0;
      req_line  <= '0;
      req_mask  <= '0;
      req_data  <= '0;
      mask2_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_nx;
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      state     <= state_nx;
      req_valid <= (state_nx != S_IDLE);
      if (load) begin
        req_line <= load_beat.line;
        req_mask <= load_beat.mask1;
        req_data <= load_beat.data;
        mask2_q  <= load_beat.mask2;
      end else if (load_second) begin
        req_line <= req_line + AW'(1);
        req_mask <= mask2_q;
        mask2_q  <= '0;
      end
    end
  end

`ifdef COPYREAD_REQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      req_cnt   <= '0;
    end else begin
      if (req_valid && !rd_in && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (grant && req_cnt != '1)                 req_cnt   <= req_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_copyread_requester.sv
// Directed bench for copyread_requester: aligned, split, wrap, len edge cases, backpressure, async reset.
module tb_copyread_requester;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [11:0]  cmd_addr;
  logic [3:0]   cmd_len;
  logic [63:0]  cmd_data;
  logic [80:0]  req_out;
  logic         req_valid;
  logic         rd_in;
  logic         idle;
`ifdef COPYREAD_REQ_STATS_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  req_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  copyread_requester #(.DEPTH(4), .AW(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .req_out(req_out), .req_valid(req_valid), .rd_in(rd_in), .idle(idle)
`ifdef COPYREAD_REQ_STATS_EN
    , .stall_cnt(stall_cnt), .req_cnt(req_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] a, input logic [3:0] l, input logic [63:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  function automatic logic [80:0] rq(input logic [8:0] line, input logic [7:0] m, input logic [63:0] d);
    return {line, m, d};
  endfunction

  initial begin
    rst_n = 1'b0; rd_in = 1'b0; cmd_valid = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_data = '0;
    #1;
    check("rst_req_valid", req_valid, 0);
    check("rst_req_out",   req_out,   0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_idle",      idle,      1);
    step(); step();
    rst_n = 1'b1;
    step();

    // aligned single request, continuous grant
    rd_in = 1'b1;
    send(12'h028, 4'd8, 64'h0807060504030201);
    check("aln_valid", req_valid, 1);
    check("aln_out",   req_out, rq(9'd5, 8'hFF, 64'h0807060504030201));
    step();
    check("aln_done_valid", req_valid, 0);
    check("aln_done_idle",  idle, 1);

    // split: line 3 offset 5 len 6, each half only on its own grant
    rd_in = 1'b0;
    send(12'h01D, 4'd6, 64'h0000FFEEDDCCBBAA);
    check("spl_first",      req_out, rq(9'd3, 8'hE0, 64'hCCBBAA0000FFEEDD));
    step(); step(); step();
    check("spl_first_hold", req_out, rq(9'd3, 8'hE0, 64'hCCBBAA0000FFEEDD));
    check("spl_first_vld",  req_valid, 1);
    rd_in = 1'b1; step(); rd_in = 1'b0;
    check("spl_second",      req_out, rq(9'd4, 8'h07, 64'hCCBBAA0000FFEEDD));
    step();
    check("spl_second_hold", req_out, rq(9'd4, 8'h07, 64'hCCBBAA0000FFEEDD));
    check("spl_second_vld",  req_valid, 1);
    rd_in = 1'b1; step(); rd_in = 1'b0;
    check("spl_done_idle", idle, 1);

    // line wrap: line 511 offset 6 len 4
    send(12'hFFE, 4'd4, 64'h00000000DDCCBBAA);
    check("wrp_first", req_out, rq(9'd511, 8'hC0, 64'hBBAA00000000DDCC));
    rd_in = 1'b1; step();
    check("wrp_second", req_out, rq(9'd0, 8'h03, 64'hBBAA00000000DDCC));
    step(); rd_in = 1'b0;
    check("wrp_done_vld", req_valid, 0);

    // len=0 discarded, len=12 clamped to 8
    send(12'h040, 4'd0, 64'hDEADBEEFDEADBEEF);
    check("len0_vld",  req_valid, 0);
    check("len0_idle", idle, 1);
    send(12'h040, 4'd12, 64'h1122334455667788);
    check("len12_out", req_out, rq(9'd8, 8'hFF, 64'h1122334455667788));
    rd_in = 1'b1; step(); rd_in = 1'b0;
    check("len12_idle", idle, 1);

    // backpressure: fresh reset so the stats start at zero
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("bp_ready_%0d", k), cmd_ready, (k < 4) ? 1 : 0);
      send({9'(16 + k), 3'd0}, 4'd8, 64'(k + 1) * 64'h0101010101010101);
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_%0d", c), req_out, rq(9'd16, 8'hFF, 64'h0101010101010101));
      step();
    end
    check("bp_hold_last", req_out, rq(9'd16, 8'hFF, 64'h0101010101010101));
    check("bp_full",      cmd_ready, 0);
`ifdef COPYREAD_REQ_STATS_EN
    check("bp_stall_cnt", stall_cnt, 10);
`endif
    rd_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_vld_%0d", k), req_valid, 1);
      check($sformatf("drain_out_%0d", k), req_out,
            rq(9'(16 + k), 8'hFF, 64'(k + 1) * 64'h0101010101010101));
      step();
    end
    rd_in = 1'b0;
    check("drain_done_vld",  req_valid, 0);
    check("drain_done_idle", idle, 1);
`ifdef COPYREAD_REQ_STATS_EN
    check("drain_req_cnt",   req_cnt, 4);
    check("drain_stall_cnt", stall_cnt, 10);
`endif

    // asynchronous reset with commands queued
    send(12'h100, 4'd8, 64'h1);
    send(12'h108, 4'd8, 64'h2);
    send(12'h110, 4'd8, 64'h3);
    check("mid_vld_before", req_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_vld",   req_valid, 0);
    check("mid_async_ready", cmd_ready, 1);
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    check("mid_after_vld",  req_valid, 0);
    check("mid_after_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
